// File: rtl/sar_request_scheduler_pkg.sv
// Shared types, constants and helpers for the SAR request scheduler.
package sar_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

  localparam int TGT_W  = 10;
  localparam int X_W    = 4;
  localparam int X_MAX  = 15;
  localparam int Y_BASE = 1000;
  localparam int Y_STEP = 30;

  // The engine's reachable y range: x=0 gives Y_BASE, x=X_MAX gives the floor.
  localparam int TGT_MAX_DEF = Y_BASE;
  localparam int TGT_MIN_DEF = Y_BASE - X_MAX * Y_STEP;

  function automatic logic [TGT_W-1:0] clamp_tgt(input logic [TGT_W-1:0] t,
                                                 input logic [TGT_W-1:0] lo,
                                                 input logic [TGT_W-1:0] hi);
    logic [TGT_W-1:0] r;
    r = t;
    if (t < lo) r = lo;
    else if (t > hi) r = hi;
    return r;
  endfunction

  function automatic logic [TGT_W-1:0] abs_diff(input logic [TGT_W-1:0] a,
                                                input logic [TGT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/sar_request_scheduler_if.sv
// Client and engine signals of the scheduler. The slave modport is the
// scheduler's view; master is the view of whatever surrounds it.
interface sar_request_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*10-1:0] target_flat;
  logic [NUM_REQ-1:0]    ack;
  logic [3:0]            res_x;
  logic [9:0]            res_y;
  logic [9:0]            res_err;
  logic                  res_timeout;
  logic                  busy;
  logic                  sar_start;
  logic [9:0]            sar_target;
  logic                  sar_done;
  logic [3:0]            sar_x;
  logic [9:0]            sar_y;

  modport slave (
    input  req, target_flat, sar_done, sar_x, sar_y,
    output ack, res_x, res_y, res_err, res_timeout, busy, sar_start, sar_target
  );

  modport master (
    output req, target_flat, sar_done, sar_x, sar_y,
    input  ack, res_x, res_y, res_err, res_timeout, busy, sar_start, sar_target
  );
endinterface

// File: rtl/sar_request_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  // Scan from the pointer upward; the first hit wins.
  always_comb begin
    int   idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    grant_oh  = '0;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = IDX_W'(idx);
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/sar_request_scheduler.sv
// Shares one SAR engine between NUM_REQ clients: arbitrates, clamps the
// target, starts the engine, waits for done under a watchdog, returns result.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  ST_IDLE  | no transaction; arbitrate when any req is set
//  ST_ISSUE | sar_start high for this one cycle, watchdog cleared
//  ST_WAIT  | waiting for a rising sar_done or watchdog expiry
//  ST_RESP  | ack pulse to the granted client, results valid
module sar_request_scheduler
  import sar_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TGT_MIN = TGT_MIN_DEF,
  parameter int TGT_MAX = TGT_MAX_DEF,
  parameter int TIMEOUT = 15
) (
  input logic                    clk,
  input logic                    rst_n,
  sar_request_scheduler_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [TGT_W-1:0] TMIN = TGT_W'(TGT_MIN);
  localparam logic [TGT_W-1:0] TMAX = TGT_W'(TGT_MAX);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  sched_state_e state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [NUM_REQ-1:0] goh_q, goh_d;
  logic [TGT_W-1:0]   tgt_q, tgt_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               done_q, done_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [X_W-1:0]     res_x_q, res_x_d;
  logic [TGT_W-1:0]   res_y_q, res_y_d;
  logic [TGT_W-1:0]   res_err_q, res_err_d;
  logic               res_to_q, res_to_d;
  logic               busy_q, busy_d;
  logic               start_q, start_d;

  logic [NUM_REQ-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               done_evt;
  logic [WD_W-1:0]    wd_inc;
  logic [IDX_W-1:0]   ptr_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (bus.req),
    .ptr       (ptr_q),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  assign done_evt = bus.sar_done & ~done_q;
  assign wd_inc   = wd_q + WD_W'(1);
  assign ptr_next = (gidx_q == IDX_LAST) ? '0 : gidx_q + IDX_W'(1);

  // Next-state and next-output computation for the whole scheduler.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    goh_d     = goh_q;
    tgt_d     = tgt_q;
    wd_d      = wd_q;
    done_d    = bus.sar_done;
    ack_d     = '0;
    res_x_d   = res_x_q;
    res_y_d   = res_y_q;
    res_err_d = res_err_q;
    res_to_d  = res_to_q;
    start_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gidx_d  = arb_idx;
          goh_d   = arb_oh;
          tgt_d   = clamp_tgt(bus.target_flat[int'(arb_idx)*TGT_W +: TGT_W], TMIN, TMAX);
          start_d = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (done_evt) begin
          res_x_d   = bus.sar_x;
          res_y_d   = bus.sar_y;
          res_err_d = abs_diff(bus.sar_y, tgt_q);
          res_to_d  = 1'b0;
          ack_d     = goh_q;
          ptr_d     = ptr_next;
          state_d   = ST_RESP;
        end else if (wd_inc == WD_LIMIT) begin
          // Engine never answered: report the top of the range and flag it.
          res_x_d   = '0;
          res_y_d   = TMAX;
          res_err_d = abs_diff(TMAX, tgt_q);
          res_to_d  = 1'b1;
          ack_d     = goh_q;
          ptr_d     = ptr_next;
          state_d   = ST_RESP;
        end else begin
          wd_d = wd_inc;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // All state and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      goh_q     <= '0;
      tgt_q     <= '0;
      wd_q      <= '0;
      done_q    <= 1'b0;
      ack_q     <= '0;
      res_x_q   <= '0;
      res_y_q   <= '0;
      res_err_q <= '0;
      res_to_q  <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      goh_q     <= goh_d;
      tgt_q     <= tgt_d;
      wd_q      <= wd_d;
      done_q    <= done_d;
      ack_q     <= ack_d;
      res_x_q   <= res_x_d;
      res_y_q   <= res_y_d;
      res_err_q <= res_err_d;
      res_to_q  <= res_to_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.res_x       = res_x_q;
  assign bus.res_y       = res_y_q;
  assign bus.res_err     = res_err_q;
  assign bus.res_timeout = res_to_q;
  assign bus.busy        = busy_q;
  assign bus.sar_start   = start_q;
  assign bus.sar_target  = tgt_q;

endmodule

// File: tb/tb_sar_request_scheduler.sv
// Bench for sar_request_scheduler: behavioural SAR engine plus a scoreboard
// of expected responses checked when ack appears.
module tb_sar_request_scheduler;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;
  localparam int LAT_OK  = 7;
  localparam int LAT_TO  = TIMEOUT + 1;

  logic clk;
  logic rst_n;
  logic engine_dead;

  sar_request_scheduler_if #(.NUM_REQ(NREQ)) bus();

  sar_request_scheduler #(
    .NUM_REQ (NREQ),
    .TGT_MIN (550),
    .TGT_MAX (1000),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int tgt;
    int x;
    int y;
    int err;
    int to;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks;
  int   n_err;
  int   ack_cnt;
  int   cyc;
  int   start_cyc;
  int   last_y;
  logic prev_start;
  int   eng_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int model_x(input int t);
    int r;
    r = 0;
    for (int x = 0; x <= 15; x++) if (1000 - 30 * x >= t) r = x;
    return r;
  endfunction

  // Behavioural engine: done rises 5 cycles after start, stays high until next start.
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.sar_done <= 1'b0;
      bus.sar_x    <= '0;
      bus.sar_y    <= '0;
      eng_cnt      <= 0;
    end else if (bus.sar_start) begin
      bus.sar_done <= 1'b0;
      bus.sar_x    <= 4'(model_x(int'(bus.sar_target)));
      bus.sar_y    <= 10'(1000 - 30 * model_x(int'(bus.sar_target)));
      eng_cnt      <= engine_dead ? 0 : 5;
    end else if (eng_cnt != 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) bus.sar_done <= 1'b1;
    end
  end

  // Monitor: start-pulse checks and scoreboard comparison on every ack.
  always @(negedge clk) begin
    cyc++;
    if (bus.sar_start) begin
      chk("start_width", prev_start, 0);
      chk("busy_run", bus.busy, 1);
      if (exp_q.size() != 0) chk("sar_target", bus.sar_target, exp_q[0].tgt);
      start_cyc = cyc;
    end
    prev_start = bus.sar_start;
    if (bus.ack != '0) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", bus.ack, 0);
      end else begin
        e = exp_q.pop_front();
        chk("ack", bus.ack, 64'(1) << e.idx);
        chk("res_x", bus.res_x, e.x);
        chk("res_y", bus.res_y, e.y);
        chk("res_err", bus.res_err, e.err);
        chk("res_timeout", bus.res_timeout, e.to);
        chk("latency", cyc - start_cyc, e.lat);
        last_y = e.y;
      end
    end
  end

  task automatic push_exp(input int c, input int ct, input int x, input int y,
                          input int err, input int to);
    exp_t n;
    n.idx = c; n.tgt = ct; n.x = x; n.y = y; n.err = err; n.to = to;
    n.lat = to ? LAT_TO : LAT_OK;
    exp_q.push_back(n);
  endtask

  task automatic wait_acks(input int base, input int n, input int budget);
    for (int i = 0; i < budget && ack_cnt < base + n; i++) tick();
    if (ack_cnt < base + n) chk("ack_wait", ack_cnt - base, n);
  endtask

  task automatic do_txn(input int c, input int t, input int ct, input int x,
                        input int y, input int err, input int to);
    int base;
    base = ack_cnt;
    push_exp(c, ct, x, y, err, to);
    bus.target_flat[c*10 +: 10] = 10'(t);
    bus.req[c] = 1'b1;
    wait_acks(base, 1, 100);
    bus.req[c] = 1'b0;
    tick();
    tick();
    chk("idle_busy", bus.busy, 0);
    chk("idle_start", bus.sar_start, 0);
    chk("res_hold", bus.res_y, last_y);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got %0d checks expected completion", n_checks);
    $fatal(1, "bench timed out");
  end

  initial begin
    int base;
    n_checks = 0; n_err = 0; ack_cnt = 0; cyc = 0; start_cyc = 0; last_y = 0;
    prev_start = 1'b0;
    engine_dead = 1'b0;
    rst_n = 1'b0;
    bus.req = '0;
    bus.target_flat = '0;
    repeat (3) tick();
    chk("rst_ack", bus.ack, 0);
    chk("rst_res_x", bus.res_x, 0);
    chk("rst_res_y", bus.res_y, 0);
    chk("rst_res_err", bus.res_err, 0);
    chk("rst_res_to", bus.res_timeout, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_start", bus.sar_start, 0);
    chk("rst_target", bus.sar_target, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_noreq_busy", bus.busy, 0);

    do_txn(0, 630, 630, 12, 640, 10, 0);
    do_txn(1, 780, 780, 7, 790, 10, 0);
    do_txn(0, 400, 550, 15, 550, 0, 0);
    do_txn(0, 1023, 1000, 0, 1000, 0, 0);
    do_txn(2, 549, 550, 15, 550, 0, 0);
    do_txn(3, 1001, 1000, 0, 1000, 0, 0);
    do_txn(2, 551, 551, 14, 580, 29, 0);

    engine_dead = 1'b1;
    do_txn(2, 700, 700, 0, 1000, 300, 1);
    engine_dead = 1'b0;

    // Reset while waiting on the engine: the transaction must vanish.
    base = ack_cnt;
    bus.target_flat[10 +: 10] = 10'd700;
    bus.req[1] = 1'b1;
    for (int i = 0; i < 20 && !bus.sar_start; i++) tick();
    chk("rst_mid_started", bus.sar_start, 1);
    tick();
    tick();
    rst_n = 1'b0;
    bus.req = '0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ack", bus.ack, 0);
    chk("mid_rst_res_x", bus.res_x, 0);
    chk("mid_rst_res_y", bus.res_y, 0);
    chk("mid_rst_res_err", bus.res_err, 0);
    chk("mid_rst_start", bus.sar_start, 0);
    chk("mid_rst_target", bus.sar_target, 0);
    repeat (20) tick();
    chk("mid_rst_no_ack", ack_cnt, base);
    last_y = 0;
    do_txn(3, 900, 900, 3, 910, 10, 0);

    // All four clients held: strict rotation starting at client 0.
    base = ack_cnt;
    bus.target_flat = {10'd900, 10'd800, 10'd700, 10'd600};
    for (int k = 0; k < 2; k++) begin
      push_exp(0, 600, 13, 610, 10, 0);
      push_exp(1, 700, 10, 700, 0, 0);
      push_exp(2, 800, 6, 820, 20, 0);
      push_exp(3, 900, 3, 910, 10, 0);
    end
    bus.req = 4'b1111;
    wait_acks(base, 8, 300);
    bus.req = '0;
    repeat (3) tick();
    chk("rr_queue_empty", exp_q.size(), 0);
    chk("final_busy", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
